hazard_pipe_ctrl: RTL and testbench

// - Producer side of the EX/MEM and MEM/WB writeback-tag interface that the forwarding unit consumes.
// - Tracks destination register and write-enable tags for each instruction through the ID/EX, EX/MEM and MEM/WB stages.
// - Detects load-use hazards and busy-multiplier hazards, and drives the PC, IF/ID and ID/EX stall, bubble and flush controls.

---
 rtl/hazard_pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipe_ctrl.sv
// Hazard and pipeline control: tracks writeback tags through ID/EX, EX/MEM and MEM/WB,
// detects load-use and busy mult/div hazards, and drives PC / IF/ID stall and flush controls.
module hazard_pipe_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_we,
    input  logic       id_mem_read,
    input  logic       id_muldiv,
    input  logic       branch_taken,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       ifid_flush,
    output logic [4:0] IDEX_Rs,
    output logic [4:0] IDEX_Rt,
    output logic [4:0] IDEX_Rd,
    output logic       IDEX_we,
    output logic [4:0] EXMEM_Rd,
    output logic       EXMEM_we,
    output logic [4:0] MEMWB_Rd,
    output logic       MEMWB_we,
    output logic       muldiv_busy,
    output logic       muldiv_done
);

    localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES);

    logic [4:0] idex_rs_q, idex_rs_d;
    logic [4:0] idex_rt_q, idex_rt_d;
    logic [4:0] idex_rd_q, idex_rd_d;
    logic       idex_we_q, idex_we_d;
    logic       idex_ld_q, idex_ld_d;
    logic [4:0] exmem_rd_q;
    logic       exmem_we_q;
    logic [4:0] memwb_rd_q;
    logic       memwb_we_q;
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    logic lu, md, stall, issue;

    always_comb begin
        lu = id_valid & idex_we_q & idex_ld_q & (idex_rd_q != 5'd0) &
             ((id_uses_rs & (id_rs == idex_rd_q)) | (id_uses_rt & (id_rt == idex_rd_q)));
        md    = id_valid & id_muldiv & (cnt_q != 4'd0);
        stall = lu | md;
        issue = id_valid & ~stall;

        idex_rs_d = '0;
        idex_rt_d = '0;
        idex_rd_d = '0;
        idex_we_d = 1'b0;
        idex_ld_d = 1'b0;
        if (issue) begin
            idex_rs_d = id_rs;
            idex_rt_d = id_rt;
            idex_rd_d = id_rd;
            idex_we_d = id_we;
            idex_ld_d = id_mem_read;
        end

        // md keeps a new mult/div out of ID/EX while counting, so a reload never interrupts one
        cnt_d = cnt_q;
        if (issue && id_muldiv) begin
            cnt_d = MD_LOAD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        done_d = (cnt_q == 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_rs_q  <= '0;
            idex_rt_q  <= '0;
            idex_rd_q  <= '0;
            idex_we_q  <= 1'b0;
            idex_ld_q  <= 1'b0;
            exmem_rd_q <= '0;
            exmem_we_q <= 1'b0;
            memwb_rd_q <= '0;
            memwb_we_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            idex_rs_q  <= idex_rs_d;
            idex_rt_q  <= idex_rt_d;
            idex_rd_q  <= idex_rd_d;
            idex_we_q  <= idex_we_d;
            idex_ld_q  <= idex_ld_d;
            exmem_rd_q <= idex_rd_q;
            exmem_we_q <= idex_we_q;
            memwb_rd_q <= exmem_rd_q;
            memwb_we_q <= exmem_we_q;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    // Held low during reset even though the registers only clear on the edge
    assign pc_we       = ~rst & ~stall;
    assign ifid_we     = ~rst & ~stall;
    assign ifid_flush  = ~rst & branch_taken & ~stall;
    assign muldiv_done = ~rst & done_q;
    assign muldiv_busy = (cnt_q != 4'd0);

    assign IDEX_Rs  = idex_rs_q;
    assign IDEX_Rt  = idex_rt_q;
    assign IDEX_Rd  = idex_rd_q;
    assign IDEX_we  = idex_we_q;
    assign EXMEM_Rd = exmem_rd_q;
    assign EXMEM_we = exmem_we_q;
    assign MEMWB_Rd = memwb_rd_q;
    assign MEMWB_we = memwb_we_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: directed vector table, multi-cycle mult/div and reset
// sequences, then random stimulus against an instruction-queue reference model.
module tb_hazard_pipe_ctrl;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_uses_rs, id_uses_rt, id_we, id_mem_read, id_muldiv, branch_taken;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       pc_we, ifid_we, ifid_flush, IDEX_we, EXMEM_we, MEMWB_we, muldiv_busy, muldiv_done;
    logic [4:0] IDEX_Rs, IDEX_Rt, IDEX_Rd, EXMEM_Rd, MEMWB_Rd;

    hazard_pipe_ctrl #(.MULDIV_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_we(id_we), .id_mem_read(id_mem_read),
        .id_muldiv(id_muldiv), .branch_taken(branch_taken), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd),
        .IDEX_we(IDEX_we), .EXMEM_Rd(EXMEM_Rd), .EXMEM_we(EXMEM_we), .MEMWB_Rd(MEMWB_Rd),
        .MEMWB_we(MEMWB_we), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: queue of issued instruction tags (front = ID/EX, then EX/MEM, MEM/WB)
    // and the cycle number of the last busy mult/div cycle.
    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       we, ld;
    } tag_t;

    tag_t   q[$];
    tag_t   zero_tag = '{rs: 5'd0, rt: 5'd0, rd: 5'd0, we: 1'b0, ld: 1'b0};
    longint cyc = 0;
    longint md_end = -10;

    function automatic logic m_busy();
        return cyc <= md_end;
    endfunction

    function automatic logic m_stall();
        logic lu, md;
        lu = id_valid && q[0].we && q[0].ld && q[0].rd != 0 &&
             ((id_uses_rs && id_rs == q[0].rd) || (id_uses_rt && id_rt == q[0].rd));
        md = id_valid && id_muldiv && m_busy();
        return lu || md;
    endfunction

    task automatic tick();
        tag_t   nt;
        logic   st;
        longint nend;
        st   = m_stall();
        nend = md_end;
        nt   = zero_tag;
        if (id_valid && !st) nt = '{rs: id_rs, rt: id_rt, rd: id_rd, we: id_we, ld: id_mem_read};
        if (id_valid && id_muldiv && !st) nend = cyc + longint'(N);
        @(posedge clk);
        if (rst) begin
            q = '{zero_tag, zero_tag, zero_tag};
            md_end = -10;
        end else begin
            q.push_front(nt);
            void'(q.pop_back());
            md_end = nend;
        end
        cyc++;
        #1;
    endtask

    task automatic check_model();
        logic st;
        st = m_stall();
        chk("pc_we", pc_we, !rst && !st);
        chk("ifid_we", ifid_we, !rst && !st);
        chk("ifid_flush", ifid_flush, !rst && branch_taken && !st);
        chk("IDEX_Rs", IDEX_Rs, q[0].rs);
        chk("IDEX_Rt", IDEX_Rt, q[0].rt);
        chk("IDEX_Rd", IDEX_Rd, q[0].rd);
        chk("IDEX_we", IDEX_we, q[0].we);
        chk("EXMEM_Rd", EXMEM_Rd, q[1].rd);
        chk("EXMEM_we", EXMEM_we, q[1].we);
        chk("MEMWB_Rd", MEMWB_Rd, q[2].rd);
        chk("MEMWB_we", MEMWB_we, q[2].we);
        chk("muldiv_busy", muldiv_busy, m_busy());
        chk("muldiv_done", muldiv_done, !rst && cyc == md_end + 1);
    endtask

    task automatic set_in(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt, input logic we,
                          input logic ld, input logic md, input logic br);
        rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt; id_we = we; id_mem_read = ld;
        id_muldiv = md; branch_taken = br;
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mult();
        set_in(0, 1, 1, 2, 0, 1, 1, 0, 0, 1, 0);
    endtask

    typedef struct {
        logic       r, v;
        logic [4:0] rs, rt, rd;
        logic       urs, urt, we, ld, md, br;
        logic       pc, fl;
        logic [4:0] xrs, xrt, xrd;
        logic       xwe;
        logic [4:0] erd;
        logic       ewe;
        logic [4:0] mrd;
        logic       mwe;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tag_t       nt;
        logic [30:0] got, exp;

        q = '{zero_tag, zero_tag, zero_tag};
        //          r v rs rt rd urs urt we ld md br | pc fl xrs xrt xrd xwe erd ewe mrd mwe
        tbl[0]  = '{1,0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0,1, 1, 0, 5, 1, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0,1, 5, 7, 6, 1, 1, 1, 0, 0, 0,  0, 0, 1, 0, 5, 1, 0, 0, 0, 0};
        tbl[4]  = '{0,1, 5, 7, 6, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 5, 1, 0, 0};
        tbl[5]  = '{0,1, 2, 0, 0, 1, 0, 1, 1, 0, 0,  1, 0, 5, 7, 6, 1, 0, 0, 5, 1};
        tbl[6]  = '{0,1, 0, 1, 6, 1, 1, 1, 0, 0, 0,  1, 0, 2, 0, 0, 1, 6, 1, 0, 0};
        tbl[7]  = '{0,1, 1, 2, 3, 1, 1, 1, 0, 0, 0,  1, 0, 0, 1, 6, 1, 0, 1, 6, 1};
        tbl[8]  = '{0,1, 3, 4, 9, 1, 1, 0, 0, 0, 0,  1, 0, 1, 2, 3, 1, 6, 1, 0, 1};
        tbl[9]  = '{0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 3, 4, 9, 0, 3, 1, 6, 1};
        tbl[10] = '{0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 9, 0, 3, 1};
        tbl[11] = '{0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 9, 0};
        tbl[12] = '{0,1, 1, 0, 2, 1, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{0,1, 2, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 1, 0, 2, 1, 0, 0, 0, 0};
        tbl[14] = '{0,1, 2, 0, 0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 2, 1, 0, 0};
        tbl[15] = '{0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0, 0, 2, 1};
        tbl[16] = '{0,0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].r, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].urs, tbl[i].urt,
                   tbl[i].we, tbl[i].ld, tbl[i].md, tbl[i].br);
            got = {pc_we, ifid_we, ifid_flush, IDEX_Rs, IDEX_Rt, IDEX_Rd, IDEX_we,
                   EXMEM_Rd, EXMEM_we, MEMWB_Rd, MEMWB_we};
            exp = {tbl[i].pc, tbl[i].pc, tbl[i].fl, tbl[i].xrs, tbl[i].xrt, tbl[i].xrd, tbl[i].xwe,
                   tbl[i].erd, tbl[i].ewe, tbl[i].mrd, tbl[i].mwe};
            chk($sformatf("vec%0d", i), {1'b0, got}, {1'b0, exp});
            chk($sformatf("vec%0d_busy", i), {muldiv_busy, muldiv_done}, 0);
            tick();
        end

        // Back-to-back mult/div: the second waits out the full countdown
        mult();
        chk("md1_issue_pc", pc_we, 1);
        chk("md1_issue_busy", muldiv_busy, 0);
        tick();
        for (int i = 0; i < int'(N); i++) begin
            mult();
            chk($sformatf("md2_stall%0d_pc", i), pc_we, 0);
            chk($sformatf("md2_stall%0d_busy", i), muldiv_busy, 1);
            chk($sformatf("md2_stall%0d_done", i), muldiv_done, 0);
            tick();
        end
        mult();
        chk("md2_issue_pc", pc_we, 1);
        chk("md2_issue_busy", muldiv_busy, 0);
        chk("md1_done", muldiv_done, 1);
        tick();
        for (int i = 0; i < int'(N); i++) begin
            idle();
            chk($sformatf("md2_cnt%0d_busy", i), muldiv_busy, 1);
            chk($sformatf("md2_cnt%0d_done", i), muldiv_done, 0);
            tick();
        end
        idle();
        chk("md2_done", muldiv_done, 1);
        chk("md2_idle_busy", muldiv_busy, 0);
        tick();
        idle();
        chk("md2_done_once", muldiv_done, 0);
        tick();

        // Reset during a countdown with cnt=2 aborts it silently
        mult();
        tick();
        idle();
        tick();
        idle();
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rstmd_busy_before", muldiv_busy, 1);
        chk("rstmd_pc_in_rst", pc_we, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("rstmd%0d_busy", i), muldiv_busy, 0);
            chk($sformatf("rstmd%0d_done", i), muldiv_done, 0);
            chk($sformatf("rstmd%0d_tags", i),
                {IDEX_Rs, IDEX_Rt, IDEX_Rd, IDEX_we, EXMEM_Rd, EXMEM_we, MEMWB_Rd, MEMWB_we}, 0);
            tick();
        end

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 64) == 0, ($urandom % 4) != 0, 5'($urandom % 4), 5'($urandom % 4),
                   5'($urandom % 4), 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom % 3) == 0, ($urandom % 6) == 0, ($urandom % 4) == 0);
            check_model();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
